// File: rtl/soc_boot_seq.sv
// SoC reset/boot sequencer: holds SoC reset, debounces and latches the boot mode,
// and drains outstanding bus traffic before a software-requested reset.
//
// state  | meaning
// HOLD   | SoC reset asserted, hold counter running
// SAMPLE | SoC reset asserted, waiting for boot_mode_i to stay stable
// RUN    | SoC released, boot mode latched and valid
// DRAIN  | software reset requested, waiting for idle or timeout
module soc_boot_seq #(
    parameter int HoldCycles   = 16,
    parameter int StableCycles = 8,
    parameter int DrainTimeout = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       test_mode_i,
    input  logic [1:0] boot_mode_i,
    input  logic       sw_rst_req_i,
    input  logic       soc_idle_i,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       boot_valid_o,
    output logic       sw_rst_ack_o,
    output logic       drain_timeout_o
);

    localparam logic [1:0] HOLD   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam logic [10:0] HoldLast   = 11'(HoldCycles - 1);
    localparam logic [10:0] StableMax  = 11'(StableCycles);
    localparam logic [15:0] DrainLast  = 16'(DrainTimeout - 1);

    logic [1:0]  state_q;
    logic [10:0] hold_cnt_q;
    logic [10:0] stable_cnt_q;
    logic [15:0] drain_cnt_q;
    logic [1:0]  capture_q;
    logic        soc_rst_q;
    logic [1:0]  boot_mode_q;
    logic        boot_valid_q;
    logic        ack_q;
    logic        timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            drain_cnt_q  <= '0;
            capture_q    <= '0;
            soc_rst_q    <= 1'b0;
            boot_mode_q  <= '0;
            boot_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    if (hold_cnt_q >= HoldLast) begin
                        state_q      <= SAMPLE;
                        hold_cnt_q   <= '0;
                        capture_q    <= boot_mode_i;
                        stable_cnt_q <= '0;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + 11'd1;
                    end
                end
                SAMPLE: begin
                    // a mismatch on the would-be latch edge still restarts the window
                    if (boot_mode_i != capture_q) begin
                        capture_q    <= boot_mode_i;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q >= StableMax) begin
                        boot_mode_q  <= capture_q;
                        boot_valid_q <= 1'b1;
                        soc_rst_q    <= 1'b1;
                        stable_cnt_q <= '0;
                        state_q      <= RUN;
                    end else if (stable_cnt_q != '1) begin
                        stable_cnt_q <= stable_cnt_q + 11'd1;
                    end
                end
                RUN: begin
                    if (sw_rst_req_i) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    // idle takes priority over a timeout landing on the same edge
                    if (soc_idle_i || (drain_cnt_q >= DrainLast)) begin
                        state_q      <= HOLD;
                        soc_rst_q    <= 1'b0;
                        boot_valid_q <= 1'b0;
                        ack_q        <= 1'b1;
                        timeout_q    <= ~soc_idle_i;
                        drain_cnt_q  <= '0;
                        hold_cnt_q   <= '0;
                    end else if (drain_cnt_q != '1) begin
                        drain_cnt_q <= drain_cnt_q + 16'd1;
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    // DFT bypass is the only logic between soc_rst_q and the pin
    assign soc_rst_no      = test_mode_i ? rst_ni : soc_rst_q;
    assign boot_mode_o     = boot_mode_q;
    assign boot_valid_o    = boot_valid_q;
    assign sw_rst_ack_o    = ack_q;
    assign drain_timeout_o = timeout_q;

endmodule
